stream_fifo_buffer: RTL

- Synchronous first-word-fall-through FIFO with valid/ready handshakes on both sides.
- Sits directly upstream of the width converter. Absorbs bursty producer traffic and presents words to the converter's valid_in/arbiter_in, honouring its ready_in.
- The converter accepts a new word only every NUM_TRANSFERS cycles in the parallel-to-serial case. This block provides the elasticity so producers need not stall on every word.

---
 rtl/stream_fifo_buffer.sv | 84 ++++++++
 1 files changed

// File: rtl/stream_fifo_buffer.sv
// First-word-fall-through FIFO with valid/ready on both sides; feeds the width
// converter and absorbs producer bursts while the converter is serialising.
module stream_fifo_buffer #(
    parameter int DATA_WIDTH  = 8,
    parameter int DEPTH       = 8,
    parameter int AFULL_LEVEL = 6
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     flush,
    input  logic                     s_valid,
    input  logic [DATA_WIDTH-1:0]    s_data,
    output logic                     s_ready,
    output logic                     m_valid,
    output logic [DATA_WIDTH-1:0]    m_data,
    input  logic                     m_ready,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     almost_full,
    output logic [$clog2(DEPTH):0]   max_level
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
    localparam logic [CW-1:0] AFULL_C = CW'(AFULL_LEVEL);

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic [CW-1:0] max_q, max_d;
    logic          push, pop;

    // Handshake outputs come only from the count register, never from s_valid/m_ready.
    assign s_ready     = (count_q != DEPTH_C);
    assign m_valid     = (count_q != '0);
    assign m_data      = m_valid ? mem[rd_ptr_q] : '0;
    assign count       = count_q;
    assign almost_full = (count_q >= AFULL_C);
    assign max_level   = max_q;

    assign push = s_valid && s_ready;
    assign pop  = m_valid && m_ready;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        max_d    = max_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
            max_d    = '0;
        end else begin
            // DEPTH is a power of two, so pointer wrap is plain overflow.
            if (push) wr_ptr_d = wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
            if (push && !pop)      count_d = count_q + 1'b1;
            else if (pop && !push) count_d = count_q - 1'b1;
            max_d = (count_d > max_q) ? count_d : max_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            max_q    <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            max_q    <= max_d;
        end
    end

    // Storage is not reset; a flushed offer must not land in the array.
    always_ff @(posedge clk) begin
        if (push && !flush) mem[wr_ptr_q] <= s_data;
    end

endmodule
